// File: rtl/dma_layer_seq.sv
// Per-layer sequencer: descriptor FIFO, then weight DMA -> activation DMA -> compute, with error/abort/watchdog.
// Build option DMA_SEQ_OVERLAP_EN runs both DMA loads concurrently instead of back to back.
module dma_layer_seq #(
   parameter int AXI_ADDR_W     = 32,
   parameter int DESC_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1 << 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          desc_valid,
   output logic                          desc_ready,
   input  logic [AXI_ADDR_W-1:0]         desc_wgt_addr,
   input  logic [AXI_ADDR_W-1:0]         desc_act_addr,
   input  logic [31:0]                   desc_num_rows,
   input  logic [31:0]                   desc_num_cols,
   input  logic [31:0]                   desc_total_blocks,
   input  logic [31:0]                   desc_act_len,
   input  logic                          abort,
   output logic                          bsr_start,
   output logic [AXI_ADDR_W-1:0]         bsr_src_addr,
   output logic [31:0]                   bsr_num_rows,
   output logic [31:0]                   bsr_num_cols,
   output logic [31:0]                   bsr_total_blocks,
   input  logic                          bsr_done,
   input  logic                          bsr_error,
   output logic                          act_start,
   output logic [AXI_ADDR_W-1:0]         act_src_addr,
   output logic [31:0]                   act_len,
   input  logic                          act_done,
   input  logic                          act_error,
   output logic                          comp_start,
   input  logic                          comp_done,
   output logic                          seq_busy,
   output logic                          seq_error,
   output logic [1:0]                    err_code,
   output logic [15:0]                   layers_done,
   output logic [$clog2(DESC_DEPTH):0]   queue_count
);

   localparam int PW = $clog2(DESC_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DESC_DEPTH);
   localparam logic [31:0]   WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

`ifdef DMA_SEQ_OVERLAP_EN
   typedef enum logic [2:0] {IDLE, LOAD_WA, REL_WA, COMP, WAIT_C, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD_W, REL_W, LOAD_A, REL_A, COMP, WAIT_C, ERR} state_t;
`endif

   state_t state;

   logic [AXI_ADDR_W-1:0] fifo_wgt    [DESC_DEPTH];
   logic [AXI_ADDR_W-1:0] fifo_act    [DESC_DEPTH];
   logic [31:0]           fifo_rows   [DESC_DEPTH];
   logic [31:0]           fifo_cols   [DESC_DEPTH];
   logic [31:0]           fifo_blocks [DESC_DEPTH];
   logic [31:0]           fifo_len    [DESC_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   logic [31:0] wd_cnt;
   logic        wd_fire;
   logic        err_now;
   logic [1:0]  err_sel;
   logic        push;
   logic        pop;
   logic        flush;

   assign desc_ready = (queue_count != FULL);
   assign push       = desc_valid && desc_ready && !abort;
   assign pop        = (state == IDLE) && (queue_count != '0) && !seq_error && !abort;
   assign flush      = abort || err_now;

`ifdef DMA_SEQ_OVERLAP_EN
   // Both loads are finished once every still-raised start sees its done this cycle.
   logic wa_loaded;
   assign wa_loaded = (!bsr_start || bsr_done) && (!act_start || act_done);
`endif

   // Error decision for this cycle; a done/error report beats the watchdog, abort beats both.
   always_comb begin
      wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIMIT);
      err_now = 1'b0;
      err_sel = 2'd0;
      if (!abort) begin
         case (state)
`ifdef DMA_SEQ_OVERLAP_EN
            LOAD_WA: begin
               if (bsr_start && bsr_done && bsr_error) begin
                  err_now = 1'b1;
                  err_sel = 2'd1;
               end else if (act_start && act_done && act_error) begin
                  err_now = 1'b1;
                  err_sel = 2'd2;
               end else if (wd_fire && !wa_loaded) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
            REL_WA: begin
               if ((bsr_done || act_done) && wd_fire) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
`else
            LOAD_W: begin
               if (bsr_done && bsr_error) begin
                  err_now = 1'b1;
                  err_sel = 2'd1;
               end else if (!bsr_done && wd_fire) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
            REL_W: begin
               if (bsr_done && wd_fire) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
            LOAD_A: begin
               if (act_done && act_error) begin
                  err_now = 1'b1;
                  err_sel = 2'd2;
               end else if (!act_done && wd_fire) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
            REL_A: begin
               if (act_done && wd_fire) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
`endif
            WAIT_C: begin
               if (!comp_done && wd_fire) begin
                  err_now = 1'b1;
                  err_sel = 2'd3;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin : desc_fifo
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_count <= '0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_count <= '0;
      end else begin
         if (push) begin
            fifo_wgt[wr_ptr]    <= desc_wgt_addr;
            fifo_act[wr_ptr]    <= desc_act_addr;
            fifo_rows[wr_ptr]   <= desc_num_rows;
            fifo_cols[wr_ptr]   <= desc_num_cols;
            fifo_blocks[wr_ptr] <= desc_total_blocks;
            fifo_len[wr_ptr]    <= desc_act_len;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   queue_count <= queue_count + 1'b1;
            2'b01:   queue_count <= queue_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin : seq_fsm
      if (!rst_n) begin
         state            <= IDLE;
         bsr_start        <= 1'b0;
         act_start        <= 1'b0;
         comp_start       <= 1'b0;
         seq_busy         <= 1'b0;
         seq_error        <= 1'b0;
         err_code         <= 2'd0;
         layers_done      <= 16'd0;
         wd_cnt           <= '0;
         bsr_src_addr     <= '0;
         bsr_num_rows     <= '0;
         bsr_num_cols     <= '0;
         bsr_total_blocks <= '0;
         act_src_addr     <= '0;
         act_len          <= '0;
      end else begin
         comp_start <= 1'b0;
         wd_cnt     <= wd_cnt + 32'd1;
         if (abort) begin
            state     <= IDLE;
            bsr_start <= 1'b0;
            act_start <= 1'b0;
            seq_busy  <= 1'b0;
            seq_error <= 1'b0;
            err_code  <= 2'd0;
            wd_cnt    <= '0;
         end else if (err_now) begin
            state     <= ERR;
            bsr_start <= 1'b0;
            act_start <= 1'b0;
            seq_busy  <= 1'b0;
            seq_error <= 1'b1;
            err_code  <= err_sel;
            wd_cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pop) begin
                     bsr_src_addr     <= fifo_wgt[rd_ptr];
                     bsr_num_rows     <= fifo_rows[rd_ptr];
                     bsr_num_cols     <= fifo_cols[rd_ptr];
                     bsr_total_blocks <= fifo_blocks[rd_ptr];
                     act_src_addr     <= fifo_act[rd_ptr];
                     act_len          <= fifo_len[rd_ptr];
                     bsr_start        <= 1'b1;
                     seq_busy         <= 1'b1;
                     wd_cnt           <= '0;
`ifdef DMA_SEQ_OVERLAP_EN
                     act_start        <= 1'b1;
                     state            <= LOAD_WA;
`else
                     state            <= LOAD_W;
`endif
                  end
               end
`ifdef DMA_SEQ_OVERLAP_EN
               LOAD_WA: begin
                  if (bsr_done) bsr_start <= 1'b0;
                  if (act_done) act_start <= 1'b0;
                  if (wa_loaded) begin
                     state  <= REL_WA;
                     wd_cnt <= '0;
                  end
               end
               REL_WA: begin
                  if (!bsr_done && !act_done) begin
                     comp_start <= 1'b1;
                     state      <= COMP;
                     wd_cnt     <= '0;
                  end
               end
`else
               LOAD_W: begin
                  if (bsr_done) begin
                     bsr_start <= 1'b0;
                     state     <= REL_W;
                     wd_cnt    <= '0;
                  end
               end
               REL_W: begin
                  if (!bsr_done) begin
                     act_start <= 1'b1;
                     state     <= LOAD_A;
                     wd_cnt    <= '0;
                  end
               end
               LOAD_A: begin
                  if (act_done) begin
                     act_start <= 1'b0;
                     state     <= REL_A;
                     wd_cnt    <= '0;
                  end
               end
               REL_A: begin
                  if (!act_done) begin
                     comp_start <= 1'b1;
                     state      <= COMP;
                     wd_cnt     <= '0;
                  end
               end
`endif
               COMP: begin
                  state  <= WAIT_C;
                  wd_cnt <= '0;
               end
               WAIT_C: begin
                  if (comp_done) begin
                     layers_done <= layers_done + 16'd1;
                     seq_busy    <= 1'b0;
                     state       <= IDLE;
                     wd_cnt      <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
